// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with clamped preset load, terminal-count flag,
// wrap/saturate at zero, a one-cycle borrow pulse and a sticky done flag.
module bcd_down_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done
);

  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'd9}};

  logic [4*DIGITS-1:0] d_clamp;
  logic [4*DIGITS-1:0] q_dec;

  always_comb begin
    d_clamp = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d_clamp[4*k +: 4] = (d[4*k +: 4] > 4'd9) ? 4'd9 : d[4*k +: 4];
    end
  end

  // Digit k only steps when every lower digit is 0 (ripple borrow, one clock).
  always_comb begin
    logic chain;
    chain = 1'b1;
    q_dec = q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (chain) begin
        q_dec[4*k +: 4] = (q[4*k +: 4] == 4'd0) ? 4'd9 : q[4*k +: 4] - 4'd1;
      end
      chain = chain && (q[4*k +: 4] == 4'd0);
    end
  end

  assign zero = (q == '0);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q      <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else if (load) begin
      q      <= d_clamp;
      borrow <= 1'b0;
      done   <= 1'b0;
    end else if (en) begin
      if (zero) begin
        if (WRAP) begin
          q      <= NINES;
          borrow <= 1'b1;
        end else begin
          borrow <= 1'b0;
        end
      end else begin
        q      <= q_dec;
        borrow <= 1'b0;
        if (q_dec == '0) done <= 1'b1;
      end
    end else begin
      borrow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed self-checking bench: two 2-digit counters (wrap and saturate) and a
// 3-digit wrapping counter share clk and clear.
module tb_bcd_down_counter;

  logic        clk = 1'b0;
  logic        clear;
  logic        a_load, a_en, b_load, b_en, c_load, c_en;
  logic [7:0]  a_d, b_d, a_q, b_q;
  logic [11:0] c_d, c_q;
  logic        a_zero, a_borrow, a_done;
  logic        b_zero, b_borrow, b_done;
  logic        c_zero, c_borrow, c_done;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .clk(clk), .clear(clear), .load(a_load), .en(a_en), .d(a_d), .q(a_q),
    .zero(a_zero), .borrow(a_borrow), .done(a_done));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_b (
    .clk(clk), .clear(clear), .load(b_load), .en(b_en), .d(b_d), .q(b_q),
    .zero(b_zero), .borrow(b_borrow), .done(b_done));

  bcd_down_counter #(.DIGITS(3), .WRAP(1'b1)) u_c (
    .clk(clk), .clear(clear), .load(c_load), .en(c_en), .d(c_d), .q(c_q),
    .zero(c_zero), .borrow(c_borrow), .done(c_done));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return 16'({4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)});
  endfunction

  initial begin
    clear = 1'b0;
    a_load = 0; a_en = 0; a_d = '0;
    b_load = 0; b_en = 0; b_d = '0;
    c_load = 0; c_en = 0; c_d = '0;
    #12;
    check("rst_q", 16'(a_q), 16'h00);
    check("rst_zero", 16'(a_zero), 16'h1);
    check("rst_borrow", 16'(a_borrow), 16'h0);
    check("rst_done", 16'(a_done), 16'h0);
    @(negedge clk);
    clear = 1'b1;
    step();
    check("rst_hold_q", 16'(a_q), 16'h00);

    // Async reset mid-count
    a_d = 8'h37; a_load = 1; step(); a_load = 0;
    check("load37_q", 16'(a_q), 16'h37);
    check("load37_zero", 16'(a_zero), 16'h0);
    #2 clear = 1'b0;
    #1;
    check("async_q", 16'(a_q), 16'h00);
    check("async_zero", 16'(a_zero), 16'h1);
    check("async_done", 16'(a_done), 16'h0);
    @(negedge clk);
    clear = 1'b1;
    step();

    // Load 12, count to zero
    a_d = 8'h12; a_load = 1; step(); a_load = 0;
    check("load12_q", 16'(a_q), 16'h12);
    check("load12_done", 16'(a_done), 16'h0);
    a_en = 1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check("cnt_q", 16'(a_q), to_bcd(12 - i));
      check("cnt_done", 16'(a_done), (i == 12) ? 16'h1 : 16'h0);
      check("cnt_zero", 16'(a_zero), (i == 12) ? 16'h1 : 16'h0);
      check("cnt_borrow", 16'(a_borrow), 16'h0);
    end

    // Wrap
    step();
    check("wrap_q", 16'(a_q), 16'h99);
    check("wrap_borrow", 16'(a_borrow), 16'h1);
    check("wrap_done", 16'(a_done), 16'h1);
    step();
    check("wrap2_q", 16'(a_q), 16'h98);
    check("wrap2_borrow", 16'(a_borrow), 16'h0);
    check("wrap2_done", 16'(a_done), 16'h1);

    // Priority and clamp
    a_d = 8'h3C; a_load = 1; step(); a_load = 0;
    check("prio_q", 16'(a_q), 16'h39);
    check("prio_done", 16'(a_done), 16'h0);
    a_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q", 16'(a_q), 16'h39);
    end

    // Saturating counter
    b_d = 8'hFA; b_load = 1; step(); b_load = 0;
    check("clampFA_q", 16'(b_q), 16'h99);
    b_d = 8'h01; b_load = 1; step(); b_load = 0;
    b_en = 1; step();
    check("sat_reach_q", 16'(b_q), 16'h00);
    check("sat_reach_done", 16'(b_done), 16'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("sat_q", 16'(b_q), 16'h00);
      check("sat_borrow", 16'(b_borrow), 16'h0);
      check("sat_done", 16'(b_done), 16'h1);
    end
    b_en = 0;

    // Three-digit cascade
    c_d = 12'h0A0; c_load = 1; step(); c_load = 0;
    check("c_clamp_q", 16'(c_q), 16'h090);
    c_d = 12'h100; c_load = 1; step(); c_load = 0;
    c_en = 1; step();
    check("c_first_q", 16'(c_q), 16'h099);
    check("c_first_done", 16'(c_done), 16'h0);
    for (int i = 1; i <= 99; i++) begin
      step();
      check("c_cnt_q", 16'(c_q), to_bcd(99 - i));
    end
    check("c_done", 16'(c_done), 16'h1);
    check("c_zero", 16'(c_zero), 16'h1);
    step();
    check("c_wrap_q", 16'(c_q), 16'h999);
    check("c_wrap_borrow", 16'(c_borrow), 16'h1);
    c_en = 0;
    step();
    check("c_borrow_drop", 16'(c_borrow), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
